mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage between EX/MEM and MEM/WB pipe registers. Runs one data-memory load/store per instruction
//  over a req/ack handshake and stalls the front of the pipeline until the access completes.
//  Presents read data on mem_result_out for the MEM/WB pipe to capture. Non-memory instructions pass in 1 cycle.
// PARAMETERS
//  ARQ          16   datapath/address width
//  TIMEOUT_CYC  255  max WAIT cycles before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk             in   1    clock; all state updates on posedge
//  rst             in   1    synchronous, active-high reset
//  mem_rd_in       in   1    EX/MEM: instruction is a load
//  mem_wr_in       in   1    EX/MEM: instruction is a store
//  addr_in         in   ARQ  EX/MEM ALU result used as address
//  wdata_in        in   ARQ  store data
//  stall_out       out  1    hold PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB
//  mem_result_out  out  ARQ  last load data (registered)
//  dmem_req        out  1    memory request, registered
//  dmem_we         out  1    1 = write, 0 = read; valid while dmem_req
//  dmem_addr       out  ARQ  latched address
//  dmem_wdata      out  ARQ  latched store data
//  dmem_rdata      in   ARQ  read data; valid with dmem_ack
//  dmem_ack        in   1    1-cycle completion pulse
//  err_out         out  1    sticky timeout flag (0 without MEM_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state IDLE. stall_out, dmem_req, dmem_we and err_out = 0. mem_result_out, dmem_addr and dmem_wdata = 0.
//  FSM states IDLE, WAIT, DONE.
//  IDLE, with rd|wr: latch addr_in, wdata_in and we=mem_wr_in, set dmem_req next edge, go to WAIT.
//    rd&wr together: the write wins and the read is dropped.
//  IDLE, neither rd nor wr: stay in IDLE, no request.
//  WAIT: hold dmem_req and the latched fields stable until dmem_ack.
//    On ack: dmem_req goes to 0 next edge and the state goes to DONE.
//    For a read, dmem_rdata is registered into mem_result_out. A write leaves mem_result_out unchanged.
//  DONE: one cycle with stall_out=0 so EX/MEM advances. Inputs are ignored (same instruction). Go to IDLE.
//  stall_out is combinational: (IDLE & (rd|wr)) | WAIT.
//  Minimum memory op is 3 cycles (IDLE, WAIT, DONE). Each extra ack latency cycle adds 1.
//  dmem_ack outside WAIT is ignored. An ack in the first WAIT cycle is legal.
//  Reset mid-access: return to IDLE, dmem_req drops at that edge, and a late ack is ignored.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//    An 8-bit-min wait counter clears on WAIT entry and counts each WAIT cycle.
//    When it reaches TIMEOUT_CYC without ack: drop dmem_req, load mem_result_out=TIMEOUT_DATA (16'hDEAD),
//    set err_out (sticky until rst), go to DONE.
//  MEM_TIMEOUT_EN undefined: WAIT lasts indefinitely, err_out tied 0, no counter logic.
// STRUCTURE
//  Package mem_stage_pkg holds:
//    typedef enum logic[1:0] {IDLE, WAIT, DONE} mem_state_t
//    localparam TIMEOUT_DATA = 16'hDEAD
//  Sub-module mem_timeout_ctr holds the WAIT-cycle counter and expiry compare.
//    It is instantiated only under MEM_TIMEOUT_EN.
// TESTING
//  Non-mem instr: rd=wr=0 for 5 cycles -> stall_out=0 throughout, dmem_req never 1.
//  Load addr 16'h0040:
//    ack 2 cycles after req with rdata 16'h1234.
//    stall_out=1 for 3 cycles, then DONE with stall 0, mem_result_out=16'h1234.
//  Store addr 16'h0010, wdata 16'hBEEF, immediate ack:
//    dmem_we=1, dmem_addr/wdata held.
//    mem_result_out unchanged, 3-cycle op.
//  rd&wr both 1: only a write request is issued (dmem_we=1). Stray ack in IDLE: no state change.
//  rst during WAIT:
//    next cycle state IDLE, dmem_req=0, stall_out=0.
//    Late ack with rdata 16'h5555 leaves mem_result_out=0.
//  MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack:
//    dmem_req drops after 4 WAIT cycles, mem_result_out=16'hDEAD, err_out=1 until rst.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared state encoding and constants for the MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_if.sv
// ============================================================================
// Module      : mem_access_stage_if
// Description : Data-memory req/ack bus between the MEM stage (master) and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_stage_if #(
    parameter int ARQ = 16
);
    logic           dmem_req;
    logic           dmem_we;
    logic [ARQ-1:0] dmem_addr;
    logic [ARQ-1:0] dmem_wdata;
    logic [ARQ-1:0] dmem_rdata;
    logic           dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Counts WAIT cycles of one access and flags expiry on the
//               TIMEOUT_CYC-th cycle without acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  clear,
    input  wire  count_en,
    output logic expired
);
    localparam int c_cnt_w = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (count_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds completed WAIT cycles, so the current cycle is number r_cnt+1
    assign expired = count_en && (r_cnt == c_cnt_w'(TIMEOUT_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage; one data-memory load/store per instruction
//               over req/ack, stalling the front end until it completes.
//               Optional abort on missing ack: define MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ARQ         = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  wire            clk,
    input  wire            rst,
    input  wire            mem_rd_in,
    input  wire            mem_wr_in,
    input  wire  [ARQ-1:0] addr_in,
    input  wire  [ARQ-1:0] wdata_in,
    output logic           stall_out,
    output logic [ARQ-1:0] mem_result_out,
    output logic           err_out,
    mem_access_stage_if.master dmem
);
    mem_state_t     r_state;
    logic           r_req;
    logic           r_we;
    logic [ARQ-1:0] r_addr;
    logic [ARQ-1:0] r_wdata;
    logic [ARQ-1:0] r_result;

    logic w_start;
    logic w_in_wait;
    logic w_expired;

    assign w_start   = (r_state == IDLE) && (mem_rd_in || mem_wr_in);
    assign w_in_wait = (r_state == WAIT);
    assign stall_out = w_start || w_in_wait;

`ifdef MEM_TIMEOUT_EN
    logic r_err;

    mem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_start),
        .count_en (w_in_wait),
        .expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_expired && !dmem.dmem_ack) begin
            r_err <= 1'b1;
        end
    end

    assign err_out = r_err;
`else
    assign w_expired = 1'b0;
    assign err_out   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_rd_in || mem_wr_in) begin
                        // A simultaneous read is dropped: the write wins
                        r_addr  <= addr_in;
                        r_wdata <= wdata_in;
                        r_we    <= mem_wr_in;
                        r_req   <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack arriving on the expiry cycle still completes normally
                    if (dmem.dmem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= DONE;
                        if (!r_we) begin
                            r_result <= dmem.dmem_rdata;
                        end
                    end else if (w_expired) begin
                        r_req    <= 1'b0;
                        r_result <= ARQ'(TIMEOUT_DATA);
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign mem_result_out  = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage with a random-latency
//               memory responder and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int ARQ = 16;
    localparam int TO  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           rd;
    logic           wr;
    logic [ARQ-1:0] addr;
    logic [ARQ-1:0] wdata;
    logic           stall;
    logic [ARQ-1:0] result;
    logic           err;

    int n_total = 0;
    int n_bad   = 0;

    logic [ARQ-1:0] exp_result;
    logic           exp_err;

    always #5 clk = ~clk;

    mem_access_stage_if #(.ARQ(ARQ)) bus ();

    mem_access_stage #(
        .ARQ         (ARQ),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_rd_in      (rd),
        .mem_wr_in      (wr),
        .addr_in        (addr),
        .wdata_in       (wdata),
        .stall_out      (stall),
        .mem_result_out (result),
        .err_out        (err),
        .dmem           (bus.master)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // One instruction end to end. lat = WAIT cycles before the ack cycle.
    // Expected stall length: 0 for non-memory, otherwise IDLE + (lat+1) WAIT
    // cycles, capped at IDLE + TO WAIT cycles when the timeout is built in.
    task automatic do_op(input logic r, input logic w, input logic [ARQ-1:0] a,
                         input logic [ARQ-1:0] d, input int lat, input logic [ARQ-1:0] rdv);
        int   stalls;
        int   reqc;
        int   exp_stalls;
        logic to_hit;
        stalls = 0;
        reqc   = 0;
`ifdef MEM_TIMEOUT_EN
        to_hit = (r || w) && (lat + 1 > TO);
`else
        to_hit = 1'b0;
`endif
        if (!(r || w))   exp_stalls = 0;
        else if (to_hit) exp_stalls = TO + 1;
        else             exp_stalls = lat + 2;

        rd = r; wr = w; addr = a; wdata = d; bus.dmem_ack = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (!stall) break;
            stalls++;
            if (bus.dmem_req) begin
                check_val("req_we",    32'(bus.dmem_we),    32'(w));
                check_val("req_addr",  32'(bus.dmem_addr),  32'(a));
                check_val("req_wdata", 32'(bus.dmem_wdata), 32'(d));
                bus.dmem_ack   = (reqc == lat);
                bus.dmem_rdata = (reqc == lat) ? rdv : ARQ'($urandom);
                reqc++;
            end else begin
                bus.dmem_ack = 1'b0;
            end
            @(negedge clk);
        end
        bus.dmem_ack = 1'b0;
        check_val("stall_cycles", 32'(stalls), 32'(exp_stalls));

        if (r || w) begin
            if (to_hit) begin
                exp_result = TIMEOUT_DATA;
                exp_err    = 1'b1;
            end else if (!w) begin
                exp_result = rdv;
            end
        end
        check_val("result",   32'(result),       32'(exp_result));
        check_val("req_done", 32'(bus.dmem_req), 32'd0);
        check_val("err",      32'(err),          32'(exp_err));

        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        exp_result = '0; exp_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_stall",  32'(stall),            32'd0);
        check_val("rst_req",    32'(bus.dmem_req),     32'd0);
        check_val("rst_we",     32'(bus.dmem_we),      32'd0);
        check_val("rst_addr",   32'(bus.dmem_addr),    32'd0);
        check_val("rst_wdata",  32'(bus.dmem_wdata),   32'd0);
        check_val("rst_result", 32'(result),           32'd0);
        check_val("rst_err",    32'(err),              32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check_val("nonmem_stall", 32'(stall),        32'd0);
            check_val("nonmem_req",   32'(bus.dmem_req), 32'd0);
        end
        @(negedge clk);

        do_op(1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'h1234);
        do_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, 16'h4321);
        do_op(1'b1, 1'b1, 16'h0020, 16'hAAAA, 0, 16'h7777);

        // Stray ack while idle must not start or complete anything
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'h9999;
        #1;
        check_val("stray_stall", 32'(stall), 32'd0);
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        #1;
        check_val("stray_req",    32'(bus.dmem_req), 32'd0);
        check_val("stray_result", 32'(result),       32'(exp_result));
        check_val("stray_stall2", 32'(stall),        32'd0);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            do_op(kind[0], kind[1], ARQ'($urandom), ARQ'($urandom),
                  $urandom_range(0, 5), ARQ'($urandom));
        end

`ifdef MEM_TIMEOUT_EN
        do_op(1'b1, 1'b0, 16'h0050, 16'h0000, 1000, 16'h0000);
        do_op(1'b0, 1'b0, 16'h0000, 16'h0000, 0, 16'h0000);
        do_op(1'b0, 1'b1, 16'h0052, 16'h1111, 0, 16'h0000);
`endif

        // Reset in the middle of an access
        rd = 1'b1; addr = 16'h0060;
        @(negedge clk);
        #1;
        check_val("mid_req_up", 32'(bus.dmem_req), 32'd1);
        rd = 1'b0; rst = 1'b1;
        @(negedge clk);
        #1;
        check_val("mid_rst_req",    32'(bus.dmem_req), 32'd0);
        check_val("mid_rst_stall",  32'(stall),        32'd0);
        check_val("mid_rst_result", 32'(result),       32'd0);
        check_val("mid_rst_err",    32'(err),          32'd0);
        rst = 1'b0; bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'h5555;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        #1;
        check_val("late_ack_result", 32'(result),       32'd0);
        check_val("late_ack_req",    32'(bus.dmem_req), 32'd0);
        check_val("late_ack_stall",  32'(stall),        32'd0);
        exp_result = '0; exp_err = 1'b0;
        @(negedge clk);
        do_op(1'b1, 1'b0, 16'h0070, 16'h0000, 2, 16'hCAFE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
